// File: rtl/pkt_packer_if.sv
// Beat-in / word-out bus for the 160-byte packer: 32-byte input beats, 160-byte output words.
interface pkt_packer_if #(
  parameter int BEATS_P      = 5,
  parameter int BEAT_BYTES_P = 32
);
  logic                                  val;
  logic                                  sop;
  logic                                  eop;
  logic [7:0]                            vbc;
  logic [BEAT_BYTES_P*8-1:0]             data;
  logic                                  i_ready;
  logic                                  o_val;
  logic                                  o_sop;
  logic                                  o_eop;
  logic [7:0]                            o_vbc;
  logic [BEATS_P*BEAT_BYTES_P*8-1:0]     o_data;
  logic                                  o_ready;
  logic                                  idle;
  logic                                  err;

  modport master (
    output val, sop, eop, vbc, data, o_ready,
    input  i_ready, o_val, o_sop, o_eop, o_vbc, o_data, idle, err
  );

  modport slave (
    input  val, sop, eop, vbc, data, o_ready,
    output i_ready, o_val, o_sop, o_eop, o_vbc, o_data, idle, err
  );
endinterface

// File: rtl/pkt_packer.sv
// Packs up to BEATS_P 32-byte beats into one wide word; word appears one cycle after its last beat.
// Backpressure: i_ready = !o_val || o_ready, so a stalled output word stops input acceptance.
module pkt_packer #(
  parameter int BEATS_P      = 5,
  parameter int BEAT_BYTES_P = 32
) (
  input logic         clk,
  input logic         reset,
  pkt_packer_if.slave bus
);
  localparam int              BW       = BEAT_BYTES_P * 8;
  localparam int              WW       = BEATS_P * BW;
  localparam int              CW       = $clog2(BEATS_P + 1);
  localparam logic [7:0]      FULL_VBC = 8'(BEAT_BYTES_P);
  localparam logic [CW-1:0]   FULL_CNT = CW'(BEATS_P);

  typedef enum logic {S_IDLE, S_PKT} state_t;

  state_t          state;
  logic [WW-1:0]   acc;
  logic [7:0]      acc_vbc;
  logic            acc_sop;
  logic [CW-1:0]   cnt;

  logic            take, drop, clamp, restart, short_beat, last, flush, violation;
  logic [7:0]      vbc_eff, base_vbc, nxt_vbc;
  logic [WW-1:0]   base_acc, nxt_acc;
  logic [CW-1:0]   base_cnt, nxt_cnt;
  logic            nxt_sop;

  assign bus.i_ready = !bus.o_val || bus.o_ready;
  assign bus.idle    = (state == S_IDLE) && (cnt == '0) && !bus.o_val;

  always_comb begin
    take       = bus.val && bus.i_ready;
    drop       = (bus.vbc == 8'd0) || ((state == S_IDLE) && !bus.sop);
    clamp      = bus.vbc > FULL_VBC;
    vbc_eff    = clamp ? FULL_VBC : bus.vbc;
    restart    = (state == S_PKT) && bus.sop;
    // A partial beat that is not marked last still ends the packet.
    short_beat = !bus.eop && (vbc_eff < FULL_VBC);
    last       = bus.eop || short_beat;

    // A mid-packet sop throws away whatever was accumulated.
    base_acc   = restart ? '0 : acc;
    base_vbc   = restart ? 8'd0 : acc_vbc;
    base_cnt   = restart ? '0 : cnt;

    nxt_acc    = {base_acc[WW-BW-1:0], bus.data};
    nxt_vbc    = base_vbc + vbc_eff;
    nxt_cnt    = base_cnt + CW'(1);
    nxt_sop    = (base_cnt == '0) ? bus.sop : acc_sop;

    flush      = take && !drop && (last || (nxt_cnt == FULL_CNT));
    violation  = take && (drop || clamp || restart || short_beat);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      acc        <= '0;
      acc_vbc    <= 8'd0;
      acc_sop    <= 1'b0;
      cnt        <= '0;
      bus.o_val  <= 1'b0;
      bus.o_sop  <= 1'b0;
      bus.o_eop  <= 1'b0;
      bus.o_vbc  <= 8'd0;
      bus.o_data <= '0;
      bus.err    <= 1'b0;
    end else begin
      bus.err <= violation;

      if (take && !drop) begin
        if (flush) begin
          acc     <= '0;
          acc_vbc <= 8'd0;
          acc_sop <= 1'b0;
          cnt     <= '0;
          state   <= last ? S_IDLE : S_PKT;
        end else begin
          acc     <= nxt_acc;
          acc_vbc <= nxt_vbc;
          acc_sop <= nxt_sop;
          cnt     <= nxt_cnt;
          state   <= S_PKT;
        end
      end

      // Reload wins over drain so consecutive words leave without a bubble.
      if (flush) begin
        bus.o_val  <= 1'b1;
        bus.o_sop  <= nxt_sop;
        bus.o_eop  <= last;
        bus.o_vbc  <= nxt_vbc;
        bus.o_data <= nxt_acc;
      end else if (bus.o_val && bus.o_ready) begin
        bus.o_val  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pkt_packer.sv
// Bench for pkt_packer: directed scenarios plus randomized traffic against a queue-based packet model.
module tb_pkt_packer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pkt_packer_if #(.BEATS_P(5), .BEAT_BYTES_P(32)) bus ();

  pkt_packer #(.BEATS_P(5), .BEAT_BYTES_P(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: beats of the open word kept as a list, word built on flush.
  bit              m_inpkt;
  logic [255:0]    m_beats[$];
  int              m_vbcs[$];
  bit              m_wsop;
  bit              m_oval, m_osop, m_oeop, m_err;
  logic [7:0]      m_ovbc;
  logic [1279:0]   m_odata;

  task automatic model_reset();
    m_inpkt = 0; m_beats.delete(); m_vbcs.delete(); m_wsop = 0;
    m_oval = 0; m_osop = 0; m_oeop = 0; m_err = 0; m_ovbc = 8'd0; m_odata = '0;
  endtask

  task automatic model_step();
    bit acc, e, fl, last;
    int v, tot, n;
    logic [1279:0] w;
    acc = bus.val && (!m_oval || bus.o_ready);
    e = 0; fl = 0; last = 0; w = '0; tot = 0;
    if (acc) begin
      v = int'(bus.vbc);
      if (v == 0 || (!m_inpkt && !bus.sop)) begin
        e = 1;
      end else begin
        if (v > 32) begin v = 32; e = 1; end
        if (m_inpkt && bus.sop) begin m_beats.delete(); m_vbcs.delete(); e = 1; end
        if (m_beats.size() == 0) m_wsop = bus.sop;
        m_beats.push_back(bus.data);
        m_vbcs.push_back(v);
        last = bus.eop;
        if (!bus.eop && v < 32) begin last = 1; e = 1; end
        if (last || m_beats.size() == 5) begin
          n = m_beats.size();
          for (int i = 0; i < n; i++) begin
            w[(n-1-i)*256 +: 256] = m_beats[i];
            tot += m_vbcs[i];
          end
          fl = 1;
          m_inpkt = !last;
          m_beats.delete(); m_vbcs.delete();
        end else begin
          m_inpkt = 1;
        end
      end
    end
    if (fl) begin
      m_oval = 1; m_osop = m_wsop; m_oeop = last; m_ovbc = 8'(tot); m_odata = w;
    end else if (m_oval && bus.o_ready) begin
      m_oval = 0;
    end
    m_err = e;
  endtask

  function automatic logic [255:0] rand_beat();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic set_beat(input bit v, input bit s, input bit e, input logic [7:0] vb, input logic [255:0] d);
    bus.val = v; bus.sop = s; bus.eop = e; bus.vbc = vb; bus.data = d;
  endtask

  task automatic idle_in();
    set_beat(0, 0, 0, 8'd0, '0);
  endtask

  task automatic adv();
    @(posedge clk);
    if (reset) model_reset(); else model_step();
    #1;
  endtask

  task automatic test_reset();
    idle_in(); bus.o_ready = 0; model_reset();
    #1 reset = 1;
    #1;
    checks++; if (bus.o_val !== 1'b0) begin errors++; $display("FAIL reset_oval: got %b want 0", bus.o_val); end
    checks++; if (bus.o_vbc !== 8'd0) begin errors++; $display("FAIL reset_ovbc: got %0d want 0", bus.o_vbc); end
    checks++; if (bus.o_data !== '0) begin errors++; $display("FAIL reset_odata: got nonzero want 0"); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
    adv(); adv();
    reset = 0;
    #1;
    checks++; if (bus.i_ready !== 1'b1) begin errors++; $display("FAIL reset_irdy: got %b want 1", bus.i_ready); end
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", bus.idle); end
  endtask

  task automatic test_single();
    logic [255:0] a = rand_beat();
    bus.o_ready = 0;
    set_beat(1, 1, 1, 8'd20, a); adv(); idle_in();
    checks++; if ({bus.o_val, bus.o_sop, bus.o_eop} !== 3'b111) begin errors++; $display("FAIL single_flags: got %b want 111", {bus.o_val, bus.o_sop, bus.o_eop}); end
    checks++; if (bus.o_vbc !== 8'd20) begin errors++; $display("FAIL single_vbc: got %0d want 20", bus.o_vbc); end
    checks++; if (bus.o_data !== {1024'b0, a}) begin errors++; $display("FAIL single_data: got %h want %h", bus.o_data, {1024'b0, a}); end
    checks++; if ({bus.idle, bus.i_ready} !== 2'b00) begin errors++; $display("FAIL single_busy: got %b want 00", {bus.idle, bus.i_ready}); end
    bus.o_ready = 1; adv();
    checks++; if ({bus.o_val, bus.idle} !== 2'b01) begin errors++; $display("FAIL single_drain: got %b want 01", {bus.o_val, bus.idle}); end
  endtask

  task automatic test_three_beats();
    logic [255:0] a = rand_beat(), b = rand_beat(), c = rand_beat();
    bus.o_ready = 1;
    set_beat(1, 1, 0, 8'd32, a); adv();
    checks++; if (bus.o_val !== 1'b0) begin errors++; $display("FAIL three_early: got %b want 0", bus.o_val); end
    set_beat(1, 0, 0, 8'd32, b); adv();
    set_beat(1, 0, 1, 8'd10, c); adv(); idle_in();
    checks++; if ({bus.o_val, bus.o_sop, bus.o_eop} !== 3'b111) begin errors++; $display("FAIL three_flags: got %b want 111", {bus.o_val, bus.o_sop, bus.o_eop}); end
    checks++; if (bus.o_vbc !== 8'd74) begin errors++; $display("FAIL three_vbc: got %0d want 74", bus.o_vbc); end
    checks++; if (bus.o_data !== {512'b0, a, b, c}) begin errors++; $display("FAIL three_data: got %h want %h", bus.o_data, {512'b0, a, b, c}); end
    adv();
    checks++; if ({bus.o_val, bus.idle} !== 2'b01) begin errors++; $display("FAIL three_drain: got %b want 01", {bus.o_val, bus.idle}); end
  endtask

  task automatic test_long();
    logic [255:0] bt [7];
    foreach (bt[i]) bt[i] = rand_beat();
    bus.o_ready = 1;
    for (int i = 0; i < 7; i++) begin
      set_beat(1, i == 0, i == 6, (i == 6) ? 8'd5 : 8'd32, bt[i]); adv();
      if (i == 4) begin
        checks++; if ({bus.o_val, bus.o_sop, bus.o_eop, bus.o_vbc} !== {3'b110, 8'd160}) begin errors++; $display("FAIL long_w1: got %b/%0d want 110/160", {bus.o_val, bus.o_sop, bus.o_eop}, bus.o_vbc); end
        checks++; if (bus.o_data !== {bt[0], bt[1], bt[2], bt[3], bt[4]}) begin errors++; $display("FAIL long_w1_data: got %h", bus.o_data); end
      end
      if (i == 5) begin
        checks++; if ({bus.o_val, bus.idle} !== 2'b00) begin errors++; $display("FAIL long_gap: got %b want 00", {bus.o_val, bus.idle}); end
      end
    end
    idle_in();
    checks++; if ({bus.o_val, bus.o_sop, bus.o_eop, bus.o_vbc} !== {3'b101, 8'd37}) begin errors++; $display("FAIL long_w2: got %b/%0d want 101/37", {bus.o_val, bus.o_sop, bus.o_eop}, bus.o_vbc); end
    checks++; if (bus.o_data !== {768'b0, bt[5], bt[6]}) begin errors++; $display("FAIL long_w2_data: got %h", bus.o_data); end
    adv();
  endtask

  task automatic test_backpressure();
    logic [255:0] p = rand_beat(), q = rand_beat();
    bus.o_ready = 0;
    set_beat(1, 1, 1, 8'd32, p); adv();
    set_beat(1, 1, 1, 8'd16, q);
    for (int i = 0; i < 10; i++) begin
      checks++; if ({bus.i_ready, bus.o_val, bus.o_vbc} !== {2'b01, 8'd32} || bus.o_data !== {1024'b0, p}) begin errors++; $display("FAIL bp_hold%0d: got irdy=%b oval=%b vbc=%0d", i, bus.i_ready, bus.o_val, bus.o_vbc); end
      adv();
    end
    bus.o_ready = 1; #1;
    checks++; if (bus.i_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", bus.i_ready); end
    adv(); idle_in();
    checks++; if ({bus.o_val, bus.o_vbc} !== {1'b1, 8'd16} || bus.o_data !== {1024'b0, q}) begin errors++; $display("FAIL bp_next: got oval=%b vbc=%0d", bus.o_val, bus.o_vbc); end
    adv();
    checks++; if (bus.o_val !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", bus.o_val); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] d;
    logic [7:0] v;
    bus.o_ready = 1;
    for (int i = 0; i < 8; i++) begin
      d = rand_beat(); v = 8'($urandom_range(1, 32));
      set_beat(1, 1, 1, v, d); adv();
      checks++; if ({bus.o_val, bus.o_vbc} !== {1'b1, v} || bus.o_data !== {1024'b0, d}) begin errors++; $display("FAIL b2b_%0d: got oval=%b vbc=%0d want 1/%0d", i, bus.o_val, bus.o_vbc, v); end
    end
    idle_in(); adv();
  endtask

  task automatic test_restart();
    logic [255:0] x1 = rand_beat(), x2 = rand_beat(), y1 = rand_beat(), y2 = rand_beat();
    bus.o_ready = 1;
    set_beat(1, 1, 0, 8'd32, x1); adv();
    set_beat(1, 0, 0, 8'd32, x2); adv();
    checks++; if ({bus.o_val, bus.err} !== 2'b00) begin errors++; $display("FAIL restart_pre: got %b want 00", {bus.o_val, bus.err}); end
    set_beat(1, 1, 0, 8'd32, y1); adv();
    checks++; if ({bus.o_val, bus.err} !== 2'b01) begin errors++; $display("FAIL restart_err: got %b want 01", {bus.o_val, bus.err}); end
    set_beat(1, 0, 1, 8'd8, y2); adv(); idle_in();
    checks++; if ({bus.o_val, bus.o_sop, bus.o_eop, bus.err, bus.o_vbc} !== {4'b1110, 8'd40}) begin errors++; $display("FAIL restart_word: got %b/%0d want 1110/40", {bus.o_val, bus.o_sop, bus.o_eop, bus.err}, bus.o_vbc); end
    checks++; if (bus.o_data !== {768'b0, y1, y2}) begin errors++; $display("FAIL restart_data: got %h", bus.o_data); end
    adv();
  endtask

  task automatic test_violations();
    logic [255:0] d = rand_beat();
    bus.o_ready = 1;
    set_beat(1, 0, 0, 8'd32, d); adv();
    checks++; if ({bus.err, bus.o_val, bus.idle} !== 3'b101) begin errors++; $display("FAIL viol_nosop: got %b want 101", {bus.err, bus.o_val, bus.idle}); end
    set_beat(1, 1, 1, 8'd0, d); adv();
    checks++; if ({bus.err, bus.o_val} !== 2'b10) begin errors++; $display("FAIL viol_zero: got %b want 10", {bus.err, bus.o_val}); end
    set_beat(1, 1, 1, 8'd40, d); adv();
    checks++; if ({bus.err, bus.o_val, bus.o_vbc} !== {2'b11, 8'd32}) begin errors++; $display("FAIL viol_clamp: got %b/%0d want 11/32", {bus.err, bus.o_val}, bus.o_vbc); end
    set_beat(1, 1, 0, 8'd7, d); adv();
    checks++; if ({bus.err, bus.o_val, bus.o_eop, bus.o_vbc} !== {3'b111, 8'd7}) begin errors++; $display("FAIL viol_short: got %b/%0d want 111/7", {bus.err, bus.o_val, bus.o_eop}, bus.o_vbc); end
    idle_in(); adv();
    checks++; if ({bus.err, bus.idle} !== 2'b01) begin errors++; $display("FAIL viol_after: got %b want 01", {bus.err, bus.idle}); end
  endtask

  task automatic test_reset_mid();
    logic [255:0] r1 = rand_beat(), r2 = rand_beat();
    bus.o_ready = 1;
    for (int i = 0; i < 8; i++) begin
      set_beat(1, i == 0, 0, 8'd32, rand_beat()); adv();
    end
    idle_in();
    #2 reset = 1; model_reset();
    #1;
    checks++; if ({bus.o_val, bus.o_sop, bus.o_eop, bus.err, bus.o_vbc} !== 12'd0) begin errors++; $display("FAIL rmid_out: got %b/%0d want 0000/0", {bus.o_val, bus.o_sop, bus.o_eop, bus.err}, bus.o_vbc); end
    checks++; if (bus.o_data !== '0) begin errors++; $display("FAIL rmid_data: got nonzero want 0"); end
    @(posedge clk); #1 reset = 0; #1;
    checks++; if ({bus.idle, bus.i_ready} !== 2'b11) begin errors++; $display("FAIL rmid_idle: got %b want 11", {bus.idle, bus.i_ready}); end
    set_beat(1, 1, 0, 8'd32, r1); adv();
    set_beat(1, 0, 1, 8'd12, r2); adv(); idle_in();
    checks++; if ({bus.o_val, bus.o_sop, bus.o_eop, bus.o_vbc} !== {3'b111, 8'd44}) begin errors++; $display("FAIL rmid_word: got %b/%0d want 111/44", {bus.o_val, bus.o_sop, bus.o_eop}, bus.o_vbc); end
    checks++; if (bus.o_data !== {768'b0, r1, r2}) begin errors++; $display("FAIL rmid_data2: got %h", bus.o_data); end
    adv();
  endtask

  task automatic test_random();
    bit holding = 0, acc, s, e;
    int pos = 0, len = $urandom_range(1, 12), r;
    logic [7:0] vb;
    for (int c = 0; c < 600; c++) begin
      if (!holding) begin
        if ($urandom_range(0, 3) != 0) begin
          holding = 1; s = (pos == 0); e = (pos == len - 1);
          vb = e ? 8'($urandom_range(1, 32)) : 8'd32;
          r = $urandom_range(0, 24);
          if (r == 0) vb = 8'd0;
          else if (r == 1) vb = 8'($urandom_range(33, 255));
          else if (r == 2) s = ~s;
          else if (r == 3 && !e) vb = 8'($urandom_range(1, 31));
          set_beat(1, s, e, vb, rand_beat());
        end else begin
          idle_in();
        end
      end
      bus.o_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      checks++; if ({bus.o_val, bus.o_sop, bus.o_eop, bus.o_vbc, bus.err, bus.i_ready, bus.idle} !== {m_oval, m_osop, m_oeop, m_ovbc, m_err, !m_oval || bus.o_ready, !m_inpkt && m_beats.size() == 0 && !m_oval}) begin
        errors++; $display("FAIL rand_ctl@%0d: got %b/%0d/%b want %b/%0d/%b", c, {bus.o_val, bus.o_sop, bus.o_eop}, bus.o_vbc, {bus.err, bus.i_ready, bus.idle}, {m_oval, m_osop, m_oeop}, m_ovbc, {m_err, !m_oval || bus.o_ready, !m_inpkt && m_beats.size() == 0 && !m_oval});
      end
      checks++; if (bus.o_data !== m_odata) begin errors++; $display("FAIL rand_data@%0d: got %h want %h", c, bus.o_data, m_odata); end
      acc = bus.val && (!m_oval || bus.o_ready);
      adv();
      if (acc) begin
        holding = 0; pos++;
        if (bus.eop || pos >= len) begin pos = 0; len = $urandom_range(1, 12); end
      end
    end
    idle_in(); bus.o_ready = 1; adv(); adv();
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_three_beats();
    test_long();
    test_backpressure();
    test_back_to_back();
    test_restart();
    test_violations();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pkt_packer.md
Name: pkt_packer

Overview:
- Upstream feeder for the 160-byte unpacker FSM.
- Accepts a packet stream of 32-byte beats (val/sop/eop/vbc/data) and packs up to 5 beats into one 160-byte word.
- Presents that word with the same val/sop/eop/vbc framing the unpacker consumes.
- Honours the unpacker's ready as downstream backpressure.

Parameters:
- BEATS_P, 5, max input beats per output word (output width = BEATS_P*32 bytes)
- BEAT_BYTES_P, 32, bytes per input beat

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- val  in  1  input beat valid
- sop  in  1  input beat is first of packet
- eop  in  1  input beat is last of packet
- vbc  in  8  valid byte count of input beat, 1..32
- data  in  256  input beat payload
- i_ready  out  1  block can accept a beat this cycle
- o_val  out  1  output word valid
- o_sop  out  1  output word holds packet start
- o_eop  out  1  output word holds packet end
- o_vbc  out  8  valid bytes in output word, 1..160
- o_data  out  1280  output word payload
- o_ready  in  1  downstream (unpacker) ready
- idle  out  1  no packet open, accumulator empty, output register empty
- err  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset (async, active-high) clears all state immediately:
  - o_val=0, o_sop=0, o_eop=0, o_vbc=0, o_data=0, err=0, cnt=0, state=IDLE.
  - i_ready=1 and idle=1 once reset deasserts.
  - Reset mid-packet discards any partial word; no output is produced for it.
- Input acceptance: a beat is accepted when val && i_ready.
  - i_ready = !o_val || o_ready. This path is combinational from o_ready.
- Accumulator: an accepted beat shifts acc left by 256 bits and writes data into slot 0 (bits 255:0).
  - After k beats, the first beat sits in slot k-1. This is the order the unpacker emits: highest occupied slot first.
  - acc_vbc += vbc (8-bit; max 160, no overflow).
  - acc_sop latches the sop of the first beat of the word.
- Flush: the word flushes on the accepted beat that has eop=1, or that makes cnt==BEATS_P.
  - On flush, on the next clk: o_val=1; o_data=acc (shifted, including this beat); o_vbc=acc_vbc; o_sop=acc_sop; o_eop=eop of that beat.
  - cnt returns to 0 on flush.
  - Latency: completing beat accepted at cycle N -> o_val=1 at N+1.
  - Output register holds all fields stable until o_val && o_ready. It then clears o_val, or reloads the same cycle if a new flush occurs (back-to-back, no bubble).
- Unused high slots of o_data (fewer than 5 beats) are zero.
- Packets longer than 160 bytes span several words: o_sop only on the first word, o_eop only on the last.
- FSM:
  - IDLE -> PKT on an accepted beat with sop=1 and eop=0.
  - IDLE stays IDLE for a single-beat packet (sop && eop).
  - PKT -> IDLE on an accepted eop beat.
  - PKT stays PKT on word-full flush without eop.
- Protocol violations (err pulses 1 cycle after the offending beat):
  - Beat in IDLE without sop: dropped.
  - vbc==0: dropped.
  - vbc>32: clamped to 32.
  - sop in PKT: current accumulator discarded; new packet started with this beat.
  - Non-eop beat with vbc<32: accepted with the given vbc and treated as eop (forced flush, o_eop=1, state -> IDLE).
- Simultaneous output accept (o_val && o_ready) and new flush in the same cycle: new word loads; o_val stays 1.
- idle = (state==IDLE) && cnt==0 && !o_val.

Test Plan:
- Single beat sop=eop=1, vbc=20, data=A -> next cycle o_val=1, o_sop=1, o_eop=1, o_vbc=20, o_data[255:0]=A, upper slots 0; idle returns to 1 after o_ready.
- Packet of 3 beats vbc=32,32,10 (data A,B,C), o_ready=1 -> one word with o_vbc=74, slot2=A, slot1=B, slot0=C, sop=eop=1.
- 7-beat packet, all vbc=32 except last vbc=5 -> word1: o_vbc=160, o_sop=1, o_eop=0; word2: o_vbc=37, o_sop=0, o_eop=1.
- Hold o_ready=0 with a word pending -> i_ready=0 and o_* stable for 10 cycles; raise o_ready -> word accepted and i_ready=1 the same cycle.
- sop arrives mid-packet after 2 beats -> err pulse; old beats are never output; new packet's word has o_sop=1.
- Assert reset after 3 beats of an open packet -> outputs 0 immediately; after release, idle=1 and the next packet is output correctly.
